// File: rtl/arb_req_mux.sv
// Requester-side front end for a 3-input arbiter: one FIFO per channel drives req,
// and a granted head entry is popped onto a shared, channel-tagged output register.
module arb_req_mux #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [2:0]      in_valid,
    input  logic [3*DW-1:0] in_data,
    output logic [2:0]      in_ready,
    output logic [2:0]      req,
    input  logic [2:0]      gnt,
    output logic            out_valid,
    output logic [1:0]      out_chan,
    output logic [DW-1:0]   out_data,
    output logic            err_multi_gnt,
    output logic            err_unreq_gnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] mem_q    [3][DEPTH];
    logic [PW-1:0] wr_ptr_q [3];
    logic [PW-1:0] rd_ptr_q [3];
    logic [CW-1:0] count_q  [3];
    logic [CW-1:0] count_d  [3];

    logic [2:0]    nonempty;
    logic [2:0]    push;
    logic [2:0]    gnt_ok;
    logic [2:0]    pop;
    logic [1:0]    pop_chan;
    logic [DW-1:0] head;
    logic          multi_gnt;
    logic          unreq_gnt;

    logic          out_valid_q;
    logic [1:0]    out_chan_q;
    logic [DW-1:0] out_data_q;
    logic          err_multi_q;
    logic          err_unreq_q;

    // Status is taken from the registered count only, so a same-cycle pop never
    // frees a slot for a same-cycle push.
    always_comb begin
        nonempty = '0;
        in_ready = '0;
        for (int i = 0; i < 3; i++) begin
            nonempty[i] = (count_q[i] != '0);
            in_ready[i] = (count_q[i] != FULL);
        end
    end

    assign req    = nonempty;
    assign push   = in_valid & in_ready;
    assign gnt_ok = gnt & nonempty;

    // Lowest-index granted non-empty channel wins when the grant is not one-hot.
    always_comb begin
        pop      = '0;
        pop_chan = '0;
        if (gnt_ok[0]) begin
            pop      = 3'b001;
            pop_chan = 2'd0;
        end else if (gnt_ok[1]) begin
            pop      = 3'b010;
            pop_chan = 2'd1;
        end else if (gnt_ok[2]) begin
            pop      = 3'b100;
            pop_chan = 2'd2;
        end
    end

    assign multi_gnt = (gnt[0] & gnt[1]) | (gnt[0] & gnt[2]) | (gnt[1] & gnt[2]);
    assign unreq_gnt = |(gnt & ~nonempty);

    always_comb begin
        head = mem_q[0][rd_ptr_q[0]];
        if (pop[1]) begin
            head = mem_q[1][rd_ptr_q[1]];
        end
        if (pop[2]) begin
            head = mem_q[2][rd_ptr_q[2]];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            count_d[i] = count_q[i];
            case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CW'(1);
                2'b01:   count_d[i] = count_q[i] - CW'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < 3; i++) begin
                count_q[i]  <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                count_q[i] <= count_d[i];
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
                end
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= |pop;
            if (|pop) begin
                out_chan_q <= pop_chan;
                out_data_q <= head;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err_multi_q <= 1'b0;
            err_unreq_q <= 1'b0;
        end else begin
            if (multi_gnt) begin
                err_multi_q <= 1'b1;
            end
            if (unreq_gnt) begin
                err_unreq_q <= 1'b1;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_chan      = out_chan_q;
    assign out_data      = out_data_q;
    assign err_multi_gnt = err_multi_q;
    assign err_unreq_gnt = err_unreq_q;

endmodule

// File: tb/tb_arb_req_mux.sv
// Directed bench for arb_req_mux: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_arb_req_mux;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic            clk;
    logic            rst_b;
    logic [2:0]      in_valid;
    logic [3*DW-1:0] in_data;
    logic [2:0]      in_ready;
    logic [2:0]      req;
    logic [2:0]      gnt;
    logic            out_valid;
    logic [1:0]      out_chan;
    logic [DW-1:0]   out_data;
    logic            err_multi_gnt;
    logic            err_unreq_gnt;

    int checks   = 0;
    int failures = 0;

    arb_req_mux #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .req           (req),
        .gnt           (gnt),
        .out_valid     (out_valid),
        .out_chan      (out_chan),
        .out_data      (out_data),
        .err_multi_gnt (err_multi_gnt),
        .err_unreq_gnt (err_unreq_gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one queue per channel plus the expected registered outputs.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    logic          m_ov;
    logic [1:0]    m_oc;
    logic [DW-1:0] m_od;
    logic          m_em;
    logic          m_eu;

    function automatic int msize(input int c);
        case (c)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic mpush(input int c, input logic [DW-1:0] d);
        case (c)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic mpop(input int c, output logic [DW-1:0] d);
        case (c)
            0:       d = q0.pop_front();
            1:       d = q1.pop_front();
            default: d = q2.pop_front();
        endcase
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        q2.delete();
        m_ov = 1'b0;
        m_oc = '0;
        m_od = '0;
        m_em = 1'b0;
        m_eu = 1'b0;
    endtask

    task automatic model_step();
        int sel;
        int sz[3];
        bit acc[3];
        logic [DW-1:0] d;
        sel = -1;
        for (int i = 0; i < 3; i++) sz[i] = msize(i);
        if ($countones(gnt) > 1) m_em = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
                if (sz[i] == 0) m_eu = 1'b1;
                else if (sel < 0) sel = i;
            end
        end
        for (int i = 0; i < 3; i++) acc[i] = in_valid[i] && (sz[i] < DEPTH);
        if (sel >= 0) begin
            mpop(sel, d);
            m_ov = 1'b1;
            m_oc = sel[1:0];
            m_od = d;
        end else begin
            m_ov = 1'b0;
        end
        for (int i = 0; i < 3; i++) if (acc[i]) mpush(i, in_data[i*DW +: DW]);
    endtask

    function automatic logic [2:0] exp_req();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (msize(i) != 0);
        return r;
    endfunction

    function automatic logic [2:0] exp_ready();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (msize(i) != DEPTH);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_b) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        chk("model.req",      32'(req),           32'(exp_req()));
        chk("model.in_ready", 32'(in_ready),      32'(exp_ready()));
        chk("model.out_valid", 32'(out_valid),    32'(m_ov));
        chk("model.out_chan", 32'(out_chan),      32'(m_oc));
        chk("model.out_data", 32'(out_data),      32'(m_od));
        chk("model.err_multi", 32'(err_multi_gnt), 32'(m_em));
        chk("model.err_unreq", 32'(err_unreq_gnt), 32'(m_eu));
    end

    function automatic logic [3*DW-1:0] pack(input logic [DW-1:0] a2, input logic [DW-1:0] a1,
                                             input logic [DW-1:0] a0);
        return {a2, a1, a0};
    endfunction

    task automatic drive(input logic [2:0] v, input logic [3*DW-1:0] d, input logic [2:0] g);
        in_valid = v;
        in_data  = d;
        gnt      = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string nm, input logic [1:0] c, input logic [DW-1:0] d);
        chk({nm, ".valid"}, 32'(out_valid), 32'd1);
        chk({nm, ".chan"},  32'(out_chan),  32'(c));
        chk({nm, ".data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        rst_b    = 1'b0;
        in_valid = '0;
        in_data  = '0;
        gnt      = '0;
        model_reset();
        @(negedge clk);
        chk("rst.req",       32'(req),           32'h0);
        chk("rst.in_ready",  32'(in_ready),      32'h7);
        chk("rst.out_valid", 32'(out_valid),     32'h0);
        chk("rst.out_data",  32'(out_data),      32'h0);
        chk("rst.errs",      32'({err_multi_gnt, err_unreq_gnt}), 32'h0);
        @(negedge clk);
        rst_b = 1'b1;

        // First push raises req the following cycle
        drive(3'b010, pack(8'h00, 8'hA1, 8'h00), 3'b000);
        chk("a1.req", 32'(req), 32'h2);
        drive(3'b000, '0, 3'b010);
        chk_out("a1.out", 2'd1, 8'hA1);
        chk("a1.req_fall", 32'(req), 32'h0);
        drive(3'b000, '0, 3'b000);
        chk("a1.idle_valid", 32'(out_valid), 32'h0);
        chk("a1.hold_data", 32'(out_data), 32'hA1);

        // One entry per channel, granted in turn
        drive(3'b111, pack(8'h33, 8'h22, 8'h11), 3'b000);
        chk("single.req", 32'(req), 32'h7);
        drive(3'b000, '0, 3'b001);
        chk_out("single.c0", 2'd0, 8'h11);
        drive(3'b000, '0, 3'b010);
        chk_out("single.c1", 2'd1, 8'h22);
        drive(3'b000, '0, 3'b100);
        chk_out("single.c2", 2'd2, 8'h33);
        chk("single.req_end", 32'(req), 32'h0);

        // Fill ch2, overflow push dropped, drain across pointer wrap
        for (int k = 1; k <= 4; k++) drive(3'b100, pack(8'(k), 8'h00, 8'h00), 3'b000);
        chk("fill.in_ready", 32'(in_ready), 32'h3);
        drive(3'b100, pack(8'h05, 8'h00, 8'h00), 3'b000);
        chk("fill.still_full", 32'(in_ready), 32'h3);
        for (int k = 1; k <= 4; k++) begin
            drive(3'b000, '0, 3'b100);
            chk_out("fill.drain", 2'd2, 8'(k));
        end
        drive(3'b000, '0, 3'b100);
        chk("stale.valid", 32'(out_valid), 32'h0);
        chk("stale.err_unreq", 32'(err_unreq_gnt), 32'h1);

        // Push+pop on full ch0 drops the push; at count 2 count stays 2
        for (int k = 0; k < 4; k++) drive(3'b001, pack(8'h00, 8'h00, 8'(8'hA0 + k)), 3'b000);
        chk("full0.in_ready", 32'(in_ready), 32'h6);
        drive(3'b001, pack(8'h00, 8'h00, 8'hB0), 3'b001);
        chk_out("full0.pop", 2'd0, 8'hA0);
        chk("full0.ready_back", 32'(in_ready), 32'h7);
        drive(3'b000, '0, 3'b001);
        chk_out("full0.pop2", 2'd0, 8'hA1);
        drive(3'b001, pack(8'h00, 8'h00, 8'hB1), 3'b001);
        chk_out("pp2.pop", 2'd0, 8'hA2);
        drive(3'b000, '0, 3'b001);
        chk_out("pp2.order1", 2'd0, 8'hA3);
        drive(3'b000, '0, 3'b001);
        chk_out("pp2.order2", 2'd0, 8'hB1);
        chk("pp2.req_end", 32'(req), 32'h0);

        // Non-one-hot grant: lowest channel only
        drive(3'b011, pack(8'h00, 8'hC1, 8'hC0), 3'b000);
        chk("multi.err_before", 32'(err_multi_gnt), 32'h0);
        drive(3'b000, '0, 3'b011);
        chk_out("multi.c0", 2'd0, 8'hC0);
        chk("multi.err", 32'(err_multi_gnt), 32'h1);
        chk("multi.req", 32'(req), 32'h2);
        drive(3'b000, '0, 3'b010);
        chk_out("multi.c1", 2'd1, 8'hC1);

        // Asynchronous reset with ch1 holding 3 entries and out_valid high
        drive(3'b011, pack(8'h00, 8'hD0, 8'hE0), 3'b000);
        drive(3'b010, pack(8'h00, 8'hD1, 8'h00), 3'b000);
        drive(3'b010, pack(8'h00, 8'hD2, 8'h00), 3'b000);
        drive(3'b000, '0, 3'b001);
        chk_out("arst.pre", 2'd0, 8'hE0);
        in_valid = '0;
        gnt      = '0;
        #2;
        rst_b = 1'b0;
        #1;
        chk("arst.valid", 32'(out_valid), 32'h0);
        chk("arst.req", 32'(req), 32'h0);
        chk("arst.errs", 32'({err_multi_gnt, err_unreq_gnt}), 32'h0);
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
        drive(3'b000, '0, 3'b010);
        chk("arst.gnt_valid", 32'(out_valid), 32'h0);
        chk("arst.err_unreq", 32'(err_unreq_gnt), 32'h1);

        // Push into empty FIFO with same-cycle grant: grant is unrequested
        drive(3'b100, pack(8'hF0, 8'h00, 8'h00), 3'b100);
        chk("pushgnt.valid", 32'(out_valid), 32'h0);
        chk("pushgnt.req", 32'(req), 32'h4);
        drive(3'b000, '0, 3'b100);
        chk_out("pushgnt.pop", 2'd2, 8'hF0);
        drive(3'b000, '0, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
